// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          DEPTH_DEFAULT = 1024;
  localparam int          HDR_BYTES     = 2;
  localparam int          WORD_BYTES    = 4;

  function automatic logic is_loading(input state_t st);
    return (st == ST_HDR) || (st == ST_DATA) || (st == ST_WRITE);
  endfunction

  function automatic logic takes_bytes(input state_t st);
    return (st == ST_HDR) || (st == ST_DATA);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs four boot bytes into one little-endian instruction word.
// full is high when the word is complete or is completed by the current shift.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  localparam logic [2:0] CNT_FULL = 3'(WORD_BYTES);
  localparam logic [2:0] CNT_LAST = 3'(WORD_BYTES - 1);

  logic [31:0] word_r;
  logic [2:0]  cnt_r;

  // Newest byte enters at the top, so the first byte of a word ends up in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= 32'h0000_0000;
      cnt_r  <= 3'd0;
    end else if (clr) begin
      word_r <= 32'h0000_0000;
      cnt_r  <= 3'd0;
    end else if (shift_en) begin
      word_r <= {byte_in, word_r[31:8]};
      cnt_r  <= cnt_r + 3'd1;
    end else begin
      word_r <= word_r;
      cnt_r  <= cnt_r;
    end
  end

  assign word = word_r;
  assign full = (cnt_r == CNT_FULL) || (shift_en && (cnt_r == CNT_LAST));

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot sequencer: loads a length-prefixed byte stream into
// memory, stalling the CPU with NOPs until the load finishes or aborts.
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int  Word_size = 32,
  parameter int  Addr_bits = 32,
  parameter int  Depth     = DEPTH_DEFAULT,
  parameter int  Timeout   = 65535,
  localparam int IW        = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  input  logic [Addr_bits-1:0] cpu_addr,
  output logic [Word_size-1:0] cpu_instr,
  output logic                 cpu_stall,
  output logic                 fetch_misalign,
  output logic [IW-1:0]        mem_raddr,
  input  logic [Word_size-1:0] mem_rdata,
  output logic                 mem_we,
  output logic [IW-1:0]        mem_waddr,
  output logic [Word_size-1:0] mem_wdata,
  output logic                 load_done,
  output logic                 load_err
);

  localparam int            TW       = $clog2(Timeout + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(Timeout - 1);
  localparam logic [16:0]   DEPTH_W  = 17'(Depth);
  localparam logic          HDR_LAST = 1'(HDR_BYTES - 1);

  state_t        state_r, state_s;
  logic          hdr_cnt_r, hdr_cnt_s;
  logic [7:0]    hdr_lo_r, hdr_lo_s;
  logic [15:0]   n_r, n_s, hdr_word_s;
  logic [IW-1:0] k_r, k_s;
  logic [TW-1:0] to_r, to_s;
  logic          done_r, done_s, err_r, err_s;
  logic          ready_r, stall_r, we_r;
  logic          xfer_s, pk_clr_s, pk_shift_s, pk_full_s;
  logic [31:0]   pk_word_s;
  logic          unused_addr_s;

  assign xfer_s     = byte_valid & ready_r;
  assign pk_shift_s = xfer_s && (state_r == ST_DATA);
  assign hdr_word_s = {byte_data, hdr_lo_r};

  imem_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pk_clr_s),
    .shift_en (pk_shift_s),
    .byte_in  (byte_data),
    .word     (pk_word_s),
    .full     (pk_full_s)
  );

  // State register plus load bookkeeping; handshake/stall/strobe follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      hdr_cnt_r <= 1'b0;
      hdr_lo_r  <= 8'h00;
      n_r       <= 16'h0000;
      k_r       <= '0;
      to_r      <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      ready_r   <= 1'b0;
      stall_r   <= 1'b0;
      we_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      hdr_cnt_r <= hdr_cnt_s;
      hdr_lo_r  <= hdr_lo_s;
      n_r       <= n_s;
      k_r       <= k_s;
      to_r      <= to_s;
      done_r    <= done_s;
      err_r     <= err_s;
      ready_r   <= takes_bytes(state_s);
      stall_r   <= is_loading(state_s);
      we_r      <= (state_s == ST_WRITE);
    end
  end

  // Next-state and bookkeeping updates.
  always_comb begin
    state_s   = state_r;
    hdr_cnt_s = hdr_cnt_r;
    hdr_lo_s  = hdr_lo_r;
    n_s       = n_r;
    k_s       = k_r;
    to_s      = to_r;
    done_s    = done_r;
    err_s     = err_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_s   = ST_HDR;
          done_s    = 1'b0;
          err_s     = 1'b0;
          hdr_cnt_s = 1'b0;
          k_s       = '0;
          to_s      = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          to_s = '0;
          if (hdr_cnt_r != HDR_LAST) begin
            hdr_lo_s  = byte_data;
            hdr_cnt_s = 1'b1;
          end else if ((hdr_word_s == 16'h0000) || ({1'b0, hdr_word_s} > DEPTH_W)) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end else begin
            n_s     = hdr_word_s;
            state_s = ST_DATA;
          end
        end else if (to_r == TO_LAST) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          to_s = to_r + TW'(1);
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          to_s = '0;
          if (pk_full_s) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_DATA;
          end
        end else if (to_r == TO_LAST) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          to_s = to_r + TW'(1);
        end
      end
      ST_WRITE: begin
        if (16'(k_r) == (n_r - 16'd1)) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          k_s     = k_r + IW'(1);
          state_s = ST_DATA;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Packer restarts each time a fresh word begins.
  assign pk_clr_s = (state_s == ST_DATA) && (state_r != ST_DATA);

  assign byte_ready     = ready_r;
  assign cpu_stall      = stall_r;
  assign mem_we         = we_r;
  assign mem_waddr      = k_r;
  assign mem_wdata      = pk_word_s;
  assign load_done      = done_r;
  assign load_err       = err_r;

  // Fetch path: upper PC bits are dropped so fetches wrap modulo Depth.
  assign mem_raddr      = cpu_addr[IW+1:2];
  assign fetch_misalign = |cpu_addr[1:0];
  assign cpu_instr      = stall_r ? NOP_INSTR : mem_rdata;
  assign unused_addr_s  = ^cpu_addr[Addr_bits-1:IW+2];

endmodule
